// File: rtl/qar_dmem_ctrl_if.sv
// ---------------------------------------------------------------------------
// qar_dmem_ctrl_if
//   Data-port bus between qar_core (master) and a data-memory slave.
//   Signals:
//     mem_valid  master->slave  request, held with addr/we/wdata until mem_ready
//     mem_we     master->slave  1=write, 0=read
//     mem_addr   master->slave  32-bit byte address
//     mem_wdata  master->slave  32-bit write data
//     mem_ready  slave->master  one-cycle completion pulse
//     mem_rdata  slave->master  read data, valid with mem_ready then held
//     mem_err    slave->master  pulses with mem_ready on an errored access
// ---------------------------------------------------------------------------
interface qar_dmem_ctrl_if;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata, mem_err
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata, mem_err
    );
endinterface

// File: rtl/qar_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// qar_dmem_ctrl
//   Word-addressed data SRAM slave for the qar_core data port. Every access
//   takes WAIT_CYCLES wait states, then completes with a one-cycle mem_ready.
//   Out-of-window or misaligned addresses complete as errored accesses
//   (no array write, no counter update, ERR_RDATA on reads).
//   Ports:
//     clk         core clock
//     rst         synchronous reset, active-high
//     bus         data-port slave (mem_valid/we/addr/wdata -> ready/rdata/err)
//     err_clr     clears err_sticky (a set in the same cycle wins)
//     err_sticky  set on any errored access
//     rd_count    completed in-range reads, saturating at 16'hFFFF
//     wr_count    completed in-range writes, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module qar_dmem_ctrl #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    qar_dmem_ctrl_if.slave        bus,
    input  logic                  err_clr,
    output logic                  err_sticky,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic                    enter_ack;

    // Transaction captured at the IDLE sample edge
    logic                    lat_we_q;
    logic [ADDR_WIDTH-1:0]   lat_idx_q;
    logic [31:0]             lat_wdata_q;
    logic                    lat_err_q;

    // Live decode of the bus
    logic                    live_in_range;
    logic [ADDR_WIDTH-1:0]   live_idx;

    // Transaction seen by the ACK-entry datapath
    logic                    txn_we;
    logic [ADDR_WIDTH-1:0]   txn_idx;
    logic [31:0]             txn_wdata;
    logic                    txn_err;

    logic [31:0]             mem_q [DEPTH];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign live_in_range = (bus.mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2])
                        && (bus.mem_addr[1:0] == 2'b00);
    assign live_idx      = bus.mem_addr[ADDR_WIDTH+1:2];

    // With zero wait states ACK is entered on the sample edge itself, so the
    // datapath must use the live bus in IDLE and the latched copy otherwise.
    always_comb begin
        txn_we    = lat_we_q;
        txn_idx   = lat_idx_q;
        txn_wdata = lat_wdata_q;
        txn_err   = lat_err_q;
        if (state_q == S_IDLE) begin
            txn_we    = bus.mem_we;
            txn_idx   = live_idx;
            txn_wdata = bus.mem_wdata;
            txn_err   = ~live_in_range;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        enter_ack = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.mem_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d   = S_ACK;
                    enter_ack = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Request capture; only meaningful once a request is sampled
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && bus.mem_valid) begin
            lat_we_q    <= bus.mem_we;
            lat_idx_q   <= live_idx;
            lat_wdata_q <= bus.mem_wdata;
            lat_err_q   <= ~live_in_range;
        end
    end

    // Array write; a reset on the ACK-entry edge suppresses it
    always_ff @(posedge clk) begin
        if (!rst && enter_ack && txn_we && !txn_err) begin
            mem_q[txn_idx] <= txn_wdata;
        end
    end

    // Read data, counters and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_rdata <= '0;
            rd_count      <= '0;
            wr_count      <= '0;
            err_sticky    <= 1'b0;
        end else begin
            if (enter_ack && !txn_we) begin
                bus.mem_rdata <= txn_err ? ERR_RDATA : mem_q[txn_idx];
            end
            if (enter_ack && !txn_err) begin
                if (txn_we) begin
                    wr_count <= sat_inc(wr_count);
                end else begin
                    rd_count <= sat_inc(rd_count);
                end
            end
            if (enter_ack && txn_err) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

    assign bus.mem_ready = (state_q == S_ACK);
    assign bus.mem_err   = (state_q == S_ACK) && lat_err_q;

endmodule
